// File: rtl/pq_mont_pkg.sv
// Shared types for the Montgomery multiplier: FSM state encoding and counter sizing.
package pq_mont_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIN,
        DONE
    } state_e;

    function automatic int cnt_bits(input int w);
        return (w > 2) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/mont_step.sv
// One radix-2 Montgomery iteration: conditionally add op1, make even with q, halve.
module mont_step #(
    parameter int W = 32
) (
    input  logic [W+1:0] acc_i,
    input  logic         op0_bit_i,
    input  logic [W-1:0] op1_i,
    input  logic [W-1:0] q_i,
    output logic [W+1:0] acc_o
);

    logic [W+1:0] t_add;
    logic [W+1:0] t_red;

    // acc < 2q and op1, q < 2^(W-1) keep t below 2^(W+1), so W+2 bits never overflow
    always_comb begin
        t_add = acc_i + (op0_bit_i ? {2'b00, op1_i} : '0);
        t_red = t_add + (t_add[0] ? {2'b00, q_i} : '0);
        acc_o = t_red >> 1;
    end

endmodule

// File: rtl/mont_mul_seq.sv
// Iterative radix-2 Montgomery multiplier, res = op0*op1*2^-W mod q, one op0 bit per cycle.
module mont_mul_seq
    import pq_mont_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  clear_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  logic [DATA_WIDTH-1:0] op0_i,
    input  logic [DATA_WIDTH-1:0] op1_i,
    input  logic [DATA_WIDTH-1:0] q_i,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic [DATA_WIDTH-1:0] res_o
);

    localparam int W  = DATA_WIDTH;
    localparam int CW = cnt_bits(W);
    localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

    state_e         state_q, state_d;
    logic [W-1:0]   op0_q, op0_d;
    logic [W-1:0]   op1_q, op1_d;
    logic [W-1:0]   q_q, q_d;
    logic [W+1:0]   acc_q, acc_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [W-1:0]   res_q, res_d;
    logic [W+1:0]   acc_step;
    logic [W+1:0]   q_ext;

    assign q_ext = {2'b00, q_q};

    mont_step #(
        .W(W)
    ) u_step (
        .acc_i    (acc_q),
        .op0_bit_i(op0_q[cnt_q]),
        .op1_i    (op1_q),
        .q_i      (q_q),
        .acc_o    (acc_step)
    );

    always_comb begin
        state_d = state_q;
        op0_d   = op0_q;
        op1_d   = op1_q;
        q_d     = q_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        res_d   = res_q;

        case (state_q)
            IDLE: begin
                if (valid_i) begin
                    op0_d   = op0_i;
                    op1_d   = op1_i;
                    q_d     = q_i;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                acc_d = acc_step;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d = FIN;
                end
            end
            FIN: begin
                // acc < 2q, so a single conditional subtract fully reduces
                res_d   = W'((acc_q >= q_ext) ? (acc_q - q_ext) : acc_q);
                state_d = DONE;
            end
            DONE: begin
                if (ready_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (clear_i) begin
            state_d = IDLE;
            acc_d   = '0;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            op0_q   <= '0;
            op1_q   <= '0;
            q_q     <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            op0_q   <= op0_d;
            op1_q   <= op1_d;
            q_q     <= q_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
        end
    end

    assign ready_o = (state_q == IDLE);
    assign valid_o = (state_q == DONE);
    assign res_o   = res_q;

endmodule

// File: tb/tb_mont_mul_seq.sv
// Scoreboard bench for mont_mul_seq: directed vectors plus back-to-back random ops with output stalls.
module tb_mont_mul_seq;
    import pq_mont_pkg::*;

    localparam logic [31:0] QD   = 32'd8380417;
    localparam logic [31:0] RMOD = 32'd4193792;

    logic        clk_i;
    logic        rst_ni;
    logic        clear_i;
    logic        valid_i;
    logic        ready_o;
    logic [31:0] op0_i;
    logic [31:0] op1_i;
    logic [31:0] q_i;
    logic        valid_o;
    logic        ready_i;
    logic [31:0] res_o;

    typedef struct {
        logic [31:0] exp;
        logic [31:0] m;
    } sb_entry_t;

    sb_entry_t sb[$];
    int        total = 0;
    int        bad   = 0;
    bit        rand_stall = 0;

    mont_mul_seq #(
        .DATA_WIDTH(32)
    ) dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clear_i(clear_i),
        .valid_i(valid_i),
        .ready_o(ready_o),
        .op0_i  (op0_i),
        .op1_i  (op1_i),
        .q_i    (q_i),
        .valid_o(valid_o),
        .ready_i(ready_i),
        .res_o  (res_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    // Golden model: (x*y mod m) multiplied by (2^-1 mod m) thirty-two times
    function automatic logic [31:0] mont_ref(input logic [31:0] x, input logic [31:0] y,
                                             input logic [31:0] m);
        logic [63:0] p;
        logic [63:0] h;
        p = (64'(x) * 64'(y)) % 64'(m);
        h = (64'(m) + 64'd1) >> 1;
        for (int i = 0; i < 32; i++) begin
            p = (p * h) % 64'(m);
        end
        return p[31:0];
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("[TB] FAIL %s got=%0d required=%0d at %0t", name, act, req, $time);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] m, input logic [31:0] exp);
        int wait_cnt;
        wait_cnt = 0;
        valid_i  = 1'b1;
        op0_i    = a;
        op1_i    = b;
        q_i      = m;
        while (ready_o !== 1'b1 && wait_cnt < 500) begin
            @(posedge clk_i);
            #1;
            wait_cnt++;
        end
        if (ready_o !== 1'b1) begin
            total++;
            bad++;
            $display("[TB] FAIL accept_timeout got=%0d required=1", ready_o);
            valid_i = 1'b0;
            return;
        end
        @(posedge clk_i);
        sb.push_back('{exp: exp, m: m});
        #1;
        valid_i = 1'b0;
        op0_i   = $urandom;
        op1_i   = $urandom;
        q_i     = $urandom;
    endtask

    task automatic drainWait();
        int wait_cnt;
        wait_cnt = 0;
        while (sb.size() != 0 && wait_cnt < 400) begin
            @(posedge clk_i);
            wait_cnt++;
        end
        #1;
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("[TB] FAIL drain_timeout got=%0d required=0", sb.size());
            sb.delete();
        end
    endtask

    // Output monitor: compares on every output handshake
    initial begin
        sb_entry_t e;
        forever begin
            @(negedge clk_i);
            if (rst_ni && valid_o && ready_i) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL unexpected_result got=%0d required=none", res_o);
                end else begin
                    e = sb.pop_front();
                    checkOutput("result", res_o, e.exp);
                    checkOutput("res_lt_q", 32'(res_o < e.m), 32'd1);
                end
            end
        end
    end

    // Accumulator bound during iteration (all issued operations are in contract)
    initial begin
        forever begin
            @(negedge clk_i);
            if (rst_ni && dut.state_q == RUN) begin
                checkOutput("acc_lt_2q", 32'(dut.acc_q < ({2'b00, dut.q_q} << 1)), 32'd1);
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk_i);
            #1;
            if (rand_stall) begin
                ready_i = ($urandom_range(0, 3) != 0);
            end
        end
    end

    initial begin
        #3000000;
        $display("[TB] FAIL watchdog got=timeout required=finish");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] m;

        rst_ni  = 1'b0;
        clear_i = 1'b0;
        valid_i = 1'b0;
        ready_i = 1'b0;
        op0_i   = '0;
        op1_i   = '0;
        q_i     = '0;

        repeat (3) @(posedge clk_i);
        #1;
        checkOutput("reset_ready", 32'(ready_o), 32'd1);
        checkOutput("reset_valid", 32'(valid_o), 32'd0);
        checkOutput("reset_res", res_o, 32'd0);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;

        $display("[TB] latency and stall hold");
        applyStimulus(32'd1, RMOD, QD, 32'd1);
        for (int i = 1; i <= 34; i++) begin
            @(negedge clk_i);
            checkOutput("busy_ready", 32'(ready_o), 32'd0);
            checkOutput("valid_timing", 32'(valid_o), 32'(i == 34));
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_i);
            checkOutput("stall_valid", 32'(valid_o), 32'd1);
            checkOutput("stall_res", res_o, 32'd1);
        end
        @(posedge clk_i);
        #1;
        ready_i = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        checkOutput("post_hs_valid", 32'(valid_o), 32'd0);
        checkOutput("post_hs_ready", 32'(ready_o), 32'd1);
        checkOutput("res_held_idle", res_o, 32'd1);
        @(posedge clk_i);
        #1;

        $display("[TB] directed vectors");
        applyStimulus(RMOD, RMOD, QD, RMOD);
        drainWait();
        applyStimulus(32'd0, QD - 32'd1, QD, 32'd0);
        drainWait();
        applyStimulus(QD - 32'd1, QD - 32'd1, QD, mont_ref(QD - 32'd1, QD - 32'd1, QD));
        drainWait();
        applyStimulus(QD - 32'd1, RMOD, QD, QD - 32'd1);
        drainWait();

        $display("[TB] clear mid-run");
        applyStimulus(32'd5, 32'd7, QD, mont_ref(32'd5, 32'd7, QD));
        repeat (15) @(posedge clk_i);
        #1;
        clear_i = 1'b1;
        @(posedge clk_i);
        #1;
        clear_i = 1'b0;
        sb.delete();
        checkOutput("clear_ready", 32'(ready_o), 32'd1);
        checkOutput("clear_valid", 32'(valid_o), 32'd0);
        repeat (40) @(negedge clk_i);
        applyStimulus(RMOD, 32'd3, QD, 32'd3);
        drainWait();

        $display("[TB] async reset mid-run");
        applyStimulus(32'd9, 32'd11, QD, mont_ref(32'd9, 32'd11, QD));
        repeat (10) @(posedge clk_i);
        #1;
        rst_ni = 1'b0;
        sb.delete();
        #1;
        checkOutput("arst_ready", 32'(ready_o), 32'd1);
        checkOutput("arst_valid", 32'(valid_o), 32'd0);
        checkOutput("arst_res", res_o, 32'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;
        applyStimulus(32'd2, RMOD, QD, 32'd2);
        drainWait();

        $display("[TB] random back-to-back with stalls");
        rand_stall = 1'b1;
        for (int i = 0; i < 800; i++) begin
            if (i < 400) begin
                m = QD;
            end else begin
                m = ($urandom_range(2, 32'h3fff_ffff) << 1) | 32'd1;
            end
            a = $urandom % m;
            b = $urandom % m;
            applyStimulus(a, b, m, mont_ref(a, b, m));
        end
        drainWait();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
